// File: rtl/sr_latch_driver.sv
// sr_latch_driver: accepts set/reset requests and sequences S/R/E (setup, enable pulse, hold)
// for a gated SR latch. Optional Q tracking/checking is enabled by `define SR_DRV_QMODEL_EN.
module sr_latch_driver #(
   parameter int SETUP_CYC = 1,
   parameter int PULSE_CYC = 2,
   parameter int HOLD_CYC  = 1,
   parameter int CNT_W     = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             set_req,
   input  logic             rst_req,
   output logic             S,
   output logic             R,
   output logic             E,
   output logic             busy,
   output logic [CNT_W-1:0] cmd_cnt,
   output logic [CNT_W-1:0] illegal_cnt,
   output logic             q_model,
   input  logic             Q,
   output logic             q_mismatch,
   output logic [1:0]       o_dbg_state
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_PULSE = 2'd2,
      ST_HOLD  = 2'd3
   } state_t;

   localparam int               PULSE_EFF  = (PULSE_CYC < 1) ? 1 : PULSE_CYC;
   localparam logic [15:0]      SETUP_LAST = 16'(SETUP_CYC - 1);
   localparam logic [15:0]      PULSE_LAST = 16'(PULSE_EFF - 1);
   localparam logic [15:0]      HOLD_LAST  = 16'(HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   state_t           r_state, w_state_nxt;
   logic [15:0]      r_cnt, w_cnt_nxt;
   logic             r_dir, w_dir_nxt;
   logic             r_s, r_r, r_e;
   logic             w_s_nxt, w_r_nxt, w_e_nxt;
   logic [CNT_W-1:0] r_cmd_cnt, r_illegal_cnt;
   logic             w_accept, w_is_set, w_is_rst, w_illegal, w_enter_pulse;

   // Valid/ready: a request transfers on a clk edge where req_valid & req_ready; req_ready is
   // high exactly in IDLE, and set_req/rst_req are only looked at on that edge.
   assign req_ready = (r_state == ST_IDLE);
   assign busy      = (r_state != ST_IDLE);
   assign w_accept  = req_valid && (r_state == ST_IDLE);
   assign w_is_set  = set_req && !rst_req;
   assign w_is_rst  = rst_req && !set_req;
   assign w_illegal = set_req && rst_req;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_dir_nxt   = r_dir;
      case (r_state)
         ST_IDLE: begin
            if (w_accept && (w_is_set || w_is_rst)) begin
               w_dir_nxt   = w_is_set;
               w_cnt_nxt   = '0;
               w_state_nxt = (SETUP_CYC > 0) ? ST_SETUP : ST_PULSE;
            end
         end
         ST_SETUP: begin
            if (r_cnt == SETUP_LAST) begin
               w_state_nxt = ST_PULSE;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + 16'd1;
            end
         end
         ST_PULSE: begin
            if (r_cnt == PULSE_LAST) begin
               w_state_nxt = (HOLD_CYC > 0) ? ST_HOLD : ST_IDLE;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + 16'd1;
            end
         end
         ST_HOLD: begin
            if (r_cnt == HOLD_LAST) begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + 16'd1;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
      // Outputs are registered from the next state so S/R/E line up with the state register.
      w_s_nxt       = (w_state_nxt != ST_IDLE) && w_dir_nxt;
      w_r_nxt       = (w_state_nxt != ST_IDLE) && !w_dir_nxt;
      w_e_nxt       = (w_state_nxt == ST_PULSE);
      w_enter_pulse = (w_state_nxt == ST_PULSE) && (r_state != ST_PULSE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= ST_IDLE;
         r_cnt         <= '0;
         r_dir         <= 1'b0;
         r_s           <= 1'b0;
         r_r           <= 1'b0;
         r_e           <= 1'b0;
         r_cmd_cnt     <= '0;
         r_illegal_cnt <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_dir   <= w_dir_nxt;
         r_s     <= w_s_nxt;
         r_r     <= w_r_nxt;
         r_e     <= w_e_nxt;
         if (w_enter_pulse)
            r_cmd_cnt <= r_cmd_cnt + CNT_ONE;
         if (w_accept && w_illegal && (r_illegal_cnt != '1))
            r_illegal_cnt <= r_illegal_cnt + CNT_ONE;
      end
   end

   assign S           = r_s;
   assign R           = r_r;
   assign E           = r_e;
   assign cmd_cnt     = r_cmd_cnt;
   assign illegal_cnt = r_illegal_cnt;
   assign o_dbg_state = r_state;

`ifdef SR_DRV_QMODEL_EN
   logic r_q_pend, r_q_pend_val, r_q_model, r_q_mismatch;

   // q_model lands one cycle after E falls; Q is not compared while that update is pending,
   // because the latch already followed the pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_q_pend     <= 1'b0;
         r_q_pend_val <= 1'b0;
         r_q_model    <= 1'b0;
         r_q_mismatch <= 1'b0;
      end else begin
         r_q_pend <= (r_state == ST_PULSE) && (w_state_nxt != ST_PULSE);
         if ((r_state == ST_PULSE) && (w_state_nxt != ST_PULSE))
            r_q_pend_val <= r_dir;
         if (r_q_pend)
            r_q_model <= r_q_pend_val;
         if ((r_state == ST_IDLE) && !r_q_pend && (Q != r_q_model))
            r_q_mismatch <= 1'b1;
      end
   end

   assign q_model    = r_q_model;
   assign q_mismatch = r_q_mismatch;
`else
   logic w_unused_q;
   assign w_unused_q = Q;
   assign q_model    = 1'b0;
   assign q_mismatch = 1'b0;
`endif

endmodule
